// File: rtl/dl_crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dl_crc_pkg
// Description : Shared types and well-known polynomial presets for the
//               dl_crc streaming CRC blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dl_crc_pkg;

    // Frame tracking state of the accumulator
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } crc_state_e;

    // CRC-32/MPEG-2: non-reflected, all-ones seed, no output inversion
    localparam logic [31:0] CRC32_MPEG2_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_MPEG2_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_MPEG2_XOROUT = 32'h0000_0000;

    // CRC-16/CCITT-FALSE: non-reflected, all-ones seed, no output inversion
    localparam logic [15:0] CRC16_CCITT_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_CCITT_XOROUT = 16'h0000;

endpackage : dl_crc_pkg
`default_nettype wire

// File: rtl/dl_crc_step.sv
`default_nettype none
// ============================================================================
// Module      : dl_crc_step
// Description : Combinational CRC update over one DATA_WIDTH word,
//               MSB-first, fully unrolled into a chain of XOR stages.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_crc_step
    import dl_crc_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC32_MPEG2_POLY
) (
    input  logic [CRC_WIDTH-1:0]  crc_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [CRC_WIDTH-1:0]  crc_out
);

    // w_stage[i] is the CRC after the first i data bits have been folded in
    logic [CRC_WIDTH-1:0] w_stage [DATA_WIDTH+1];

    assign w_stage[0] = crc_in;

    // One stage per data bit; bit DATA_WIDTH-1 enters first
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        logic                 w_fb;
        logic [CRC_WIDTH-1:0] w_shift;
        logic [CRC_WIDTH-1:0] w_mask;

        dl_xor #(.WIDTH(1)) u_fb (
            .i_a (w_stage[i][CRC_WIDTH-1]),
            .i_b (data_in[DATA_WIDTH-1-i]),
            .o_y (w_fb)
        );

        assign w_shift = w_stage[i] << 1;
        assign w_mask  = w_fb ? POLY : '0;

        dl_xor #(.WIDTH(CRC_WIDTH)) u_fold (
            .i_a (w_shift),
            .i_b (w_mask),
            .o_y (w_stage[i+1])
        );
    end : g_bit

    assign crc_out = w_stage[DATA_WIDTH];

endmodule : dl_crc_step
`default_nettype wire

// File: rtl/dl_xor.sv
`default_nettype none
// ============================================================================
// Module      : dl_xor
// Description : Bitwise XOR primitive of the dl_xor layer.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_xor #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_a ^ i_b;

endmodule : dl_xor
`default_nettype wire

// File: rtl/dl_crc_accum.sv
`default_nettype none
// ============================================================================
// Module      : dl_crc_accum
// Description : Streaming CRC accumulator. Folds one word per cycle into a
//               running CRC and presents the finished frame CRC over a
//               valid/ready output that is held until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_crc_accum
    import dl_crc_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC32_MPEG2_POLY,
    parameter logic [CRC_WIDTH-1:0] INIT       = CRC32_MPEG2_INIT,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT    = CRC32_MPEG2_XOROUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CRC_WIDTH-1:0]  out_crc,
    output logic                  busy
);

    crc_state_e           r_state;
    logic [CRC_WIDTH-1:0] r_crc;
    logic                 r_out_valid;
    logic [CRC_WIDTH-1:0] r_out_crc;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_start;
    logic [CRC_WIDTH-1:0] w_base;
    logic [CRC_WIDTH-1:0] w_next;

    // A held result blocks input unless it is being popped this cycle,
    // which also freezes crc_reg and state under backpressure.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = r_out_valid && out_ready;

    // Any word taken in IDLE opens a frame; in_first mid-frame restarts it
    assign w_start  = (r_state == IDLE) || in_first;
    assign w_base   = w_start ? INIT : r_crc;

    dl_crc_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH),
        .POLY       (POLY)
    ) u_step (
        .crc_in  (w_base),
        .data_in (in_data),
        .crc_out (w_next)
    );

    // Frame FSM, running CRC and output holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_crc       <= INIT;
            r_out_valid <= 1'b0;
            r_out_crc   <= '0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (in_last) begin
                    r_out_crc   <= w_next ^ XOR_OUT;
                    r_out_valid <= 1'b1;
                    r_crc       <= INIT;
                    r_state     <= IDLE;
                end else begin
                    r_crc       <= w_next;
                    r_state     <= ACCUM;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_crc   = r_out_crc;
    assign busy      = (r_state == ACCUM);

endmodule : dl_crc_accum
`default_nettype wire
